// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL delay-sweep controller: FSM state
// encoding, FDA field positions and helpers for counter sizing / code packing.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_WAIT_LOCK,
    ST_LOCK_SETTLE,
    ST_IDLE,
    ST_STEP_SETTLE,
    ST_MEAS,
    ST_ERROR
  } state_e;

  localparam int unsigned FDA_REL_MSB = 7;
  localparam int unsigned FDA_REL_LSB = 4;
  localparam int unsigned FDA_FB_MSB  = 3;
  localparam int unsigned FDA_FB_LSB  = 0;

  // Width needed for a down-counter loaded with max_val - 1.
  function automatic int cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

  // Place the swept code in the selected FDA field; the other field stays 0.
  function automatic logic [7:0] fda_pack(input logic sel, input logic [3:0] code);
    logic [7:0] fda;
    fda = 8'h00;
    if (sel) fda[FDA_FB_MSB:FDA_FB_LSB] = code;
    else     fda[FDA_REL_MSB:FDA_REL_LSB] = code;
    return fda;
  endfunction

endpackage

// File: rtl/pll_delay_sweep_ctrl_sync2.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0 so a
// stale lock indication can never leak out of reset.
module sync2 (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments make both flops sample on the same edge,
  // giving a true two-stage pipeline rather than a single flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_delay_sweep_ctrl.sv
// PLL bring-up, lock qualification and FDA delay-code sweep controller; hands
// each settled code to the TDC capture logic over a meas_req/meas_ack handshake.
module pll_delay_sweep_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SETTLE_CYCLES = 256
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_lock,
  output logic       pll_resetb,
  output logic [7:0] pll_dynamicdelay,
  input  logic       sweep_start,
  input  logic       sweep_sel,
  input  logic [3:0] sweep_first,
  input  logic [3:0] sweep_last,
  output logic       meas_req,
  output logic [3:0] meas_code,
  input  logic       meas_ack,
  output logic       locked,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_MAX_RS = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX    = (LOCK_TIMEOUT > CNT_MAX_RS) ? LOCK_TIMEOUT : CNT_MAX_RS;
  localparam int          CNT_W      = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] RESET_LOAD   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);

  logic lock_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       last_q, last_d;
  logic             sel_q, sel_d;
  logic             up_q, up_d;
  logic             resetb_q, resetb_d;
  logic [7:0]       fda_q, fda_d;
  logic             meas_req_q, meas_req_d;
  logic             locked_q, locked_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  sync2 u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (pll_lock),
    .q       (lock_s)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    last_d  = last_q;
    sel_d   = sel_q;
    up_d    = up_q;
    error_d = error_q;
    done_d  = 1'b0;

    case (state_q)
      ST_RST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_LOCK_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LOCK_SETTLE, ST_STEP_SETTLE: begin
        if (cnt_q == '0) state_d = (state_q == ST_LOCK_SETTLE) ? ST_IDLE : ST_MEAS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_IDLE: begin
        if (sweep_start) begin
          state_d = ST_STEP_SETTLE;
          cnt_d   = SETTLE_LOAD;
          code_d  = sweep_first;
          last_d  = sweep_last;
          sel_d   = sweep_sel;
          up_d    = (sweep_first < sweep_last);
          error_d = 1'b0;
        end
      end
      ST_MEAS: begin
        if (meas_ack) begin
          if (code_q == last_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_STEP_SETTLE;
            cnt_d   = SETTLE_LOAD;
            code_d  = up_q ? code_q + 4'd1 : code_q - 4'd1;
          end
        end
      end
      ST_ERROR: begin
        if (sweep_start) begin
          state_d = ST_RST_HOLD;
          cnt_d   = RESET_LOAD;
          error_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_RST_HOLD;
        cnt_d   = RESET_LOAD;
      end
    endcase

    // Lock loss overrides any step or done decided above and forces a relock.
    if (!lock_s && (state_q inside {ST_LOCK_SETTLE, ST_IDLE, ST_STEP_SETTLE, ST_MEAS})) begin
      state_d = ST_RST_HOLD;
      cnt_d   = RESET_LOAD;
      code_d  = 4'd0;
      sel_d   = 1'b0;
      error_d = 1'b1;
      done_d  = 1'b0;
    end

    resetb_d   = !(state_d inside {ST_RST_HOLD, ST_ERROR});
    locked_d   = (state_d inside {ST_IDLE, ST_STEP_SETTLE, ST_MEAS});
    busy_d     = (state_d inside {ST_STEP_SETTLE, ST_MEAS});
    meas_req_d = (state_d == ST_MEAS);
    fda_d      = fda_pack(sel_d, code_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RST_HOLD;
      cnt_q      <= RESET_LOAD;
      code_q     <= 4'd0;
      last_q     <= 4'd0;
      sel_q      <= 1'b0;
      up_q       <= 1'b0;
      resetb_q   <= 1'b0;
      fda_q      <= 8'h00;
      meas_req_q <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      up_q       <= up_d;
      resetb_q   <= resetb_d;
      fda_q      <= fda_d;
      meas_req_q <= meas_req_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign pll_resetb       = resetb_q;
  assign pll_dynamicdelay = fda_q;
  assign meas_req         = meas_req_q;
  assign meas_code        = code_q;
  assign locked           = locked_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: doc/pll_delay_sweep_ctrl.md
# pll_delay_sweep_ctrl

Fabric-clock controller that brings the iCE40 TDC PLL out of reset, qualifies lock, and sweeps the PLL's dynamic fine-delay code (FDA) one step at a time for TDC characterisation. After each code change it waits a settle interval, then hands a measurement window to the TDC capture logic over a req/ack handshake. It sits between the PLL wrapper (`RESETB`, `LOCK`, `DYNAMICDELAY` pins) and the TDC measurement/readout logic.

## Interface
Parameters:
- `RESET_CYCLES`, 16: cycles `pll_resetb` is held low after reset or relock request (≥1).
- `LOCK_TIMEOUT`, 65535: max cycles waiting for synchronised lock before error (≥1, ≤2^20−1).
- `SETTLE_CYCLES`, 256: cycles after any delay-code change or lock acquisition before proceeding (≥1).

Ports:
- `clock`  in  1  fabric clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pll_lock`  in  1  raw PLL LOCK, asynchronous to `clock`.
- `pll_resetb`  out  1  PLL RESETB, active low.
- `pll_dynamicdelay`  out  8  [7:4] relative FDA, [3:0] feedback FDA.
- `sweep_start`  in  1  single-cycle start pulse.
- `sweep_sel`  in  1  0 = sweep relative field, 1 = feedback field; other field held 0.
- `sweep_first`  in  4  first code (inclusive).
- `sweep_last`  in  4  last code (inclusive).
- `meas_req`  out  1  measurement window open for current code.
- `meas_code`  out  4  code currently applied (valid while `meas_req`).
- `meas_ack`  in  1  measurement logic finished current step.
- `locked`  out  1  PLL locked and settled.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse, sweep completed normally.
- `error`  out  1  sticky: lock timeout or lock loss; cleared by next accepted `sweep_start`.

## Operation
- `pll_lock` passes a 2-flop synchroniser → `lock_s`; all logic uses `lock_s`.
- States: `RST_HOLD` → `WAIT_LOCK` → `LOCK_SETTLE` → `IDLE` → `STEP_SETTLE` → `MEAS` → (`STEP_SETTLE` | `IDLE`); `ERROR`.
- `RST_HOLD`: `pll_resetb`=0, delay code 0x00; after `RESET_CYCLES` → `WAIT_LOCK`.
- `WAIT_LOCK`: count cycles; `lock_s`=1 → `LOCK_SETTLE`; count reaches `LOCK_TIMEOUT` → `ERROR`.
- `LOCK_SETTLE`: `SETTLE_CYCLES` of continuous `lock_s` → `IDLE`, `locked`=1.
- `IDLE`: `sweep_start`=1 → load code=`sweep_first` into selected field, clear `error`, `busy`=1, → `STEP_SETTLE`.
- `STEP_SETTLE`: `SETTLE_CYCLES` → `MEAS`, `meas_req`=1.
- `MEAS`: hold `meas_req` until `meas_ack`. On ack: code == `sweep_last` → `IDLE`, `done` pulse, `busy`=0; else code steps ±1 toward `sweep_last` (up if first<last, down if first>last), → `STEP_SETTLE`.
- `first == last`: exactly one step. No wrap-around; 4-bit code never passes 0 or 15.
- `sweep_first`/`sweep_last`/`sweep_sel` captured at start; changes mid-sweep ignored.
- `sweep_start` outside `IDLE` ignored. `meas_ack` outside `MEAS` ignored.
- `lock_s`=0 in `LOCK_SETTLE`, `IDLE`, `STEP_SETTLE` or `MEAS`: set `error`, drop `locked`/`busy`/`meas_req`, no `done`, → `RST_HOLD` (automatic relock).
- `ERROR` (lock timeout): `pll_resetb`=0, `error`=1; `sweep_start` → `RST_HOLD` (retry), error cleared.
- After a normal sweep the last code stays applied in `IDLE`.

## Timing
- Reset values: `pll_resetb`=0, `pll_dynamicdelay`=0x00, `meas_req`=0, `meas_code`=0, `locked`=0, `busy`=0, `done`=0, `error`=0; state `RST_HOLD`.
- All outputs registered.
- Lock path latency: 2 cycles synchroniser.
- `sweep_start` high in cycle N (state `IDLE`) → code and `busy` valid at N+1; `meas_req` rises at N+1+`SETTLE_CYCLES`.
- `meas_ack` high in cycle M → `meas_req` low at M+1; next code applied at M+1; next `meas_req` at M+1+`SETTLE_CYCLES`.
- Last step: `done`=1 and `busy`=0 at M+1; `done` low at M+2.
- `meas_ack` coincident with lock loss: lock loss wins (error, no step/done).

## Structure
- Package `pll_ctrl_pkg`: state enum, `FDA_REL_MSB/LSB`=7/4, `FDA_FB_MSB/LSB`=3/0, counter width derived from `LOCK_TIMEOUT`.
- One shared down-counter serves reset hold, lock timeout and settle.
- Sub-module: `sync2` (2-flop synchroniser, async active-low reset to 0).

## Test plan
- Reset, `pll_lock` rises 100 cycles after `pll_resetb` → `locked`=1 exactly 2+`SETTLE_CYCLES` cycles after lock edge; `pll_dynamicdelay`=0x00.
- `pll_lock` held 0 → `error`=1 after `LOCK_TIMEOUT` cycles in `WAIT_LOCK`, `pll_resetb`=0; `sweep_start` → retry, error cleared.
- `sweep_sel`=0, first=2, last=5, ack 3 cycles after each req → `meas_code` 2,3,4,5; `pll_dynamicdelay` 0x20..0x50; one `done`.
- `sweep_sel`=1, first=15, last=13 → codes 15,14,13, delay 0x0F,0x0E,0x0D; first=last=7 → single step, `done`.
- Drop `pll_lock` during `MEAS` on step 2 → `meas_req`/`busy` low, `error`=1, no `done`, relock sequence restarts with code 0x00.
- `sweep_start` while `busy`, and `meas_ack` in `STEP_SETTLE` → both ignored, sweep sequence unchanged.
